// File: rtl/kairo_lsu_if.sv
// kairo_lsu_if: data-bus req/ack interface between the LSU (master) and memory (slave)
interface kairo_lsu_if;
  logic        D_REQ;
  logic        D_WE;
  logic [31:0] D_ADDR;
  logic [3:0]  D_BE;
  logic [31:0] D_WDATA;
  logic        D_ACK;
  logic [31:0] D_RDATA;
  modport master(output D_REQ, D_WE, D_ADDR, D_BE, D_WDATA, input D_ACK, D_RDATA);
  modport slave(input D_REQ, D_WE, D_ADDR, D_BE, D_WDATA, output D_ACK, D_RDATA);
endinterface

// File: rtl/kairo_lsu.sv
// kairo_lsu: load/store unit, one bus transaction per request with lane steering and load extension; KAIRO_LSU_TIMEOUT_EN adds an ACCESS timeout
module kairo_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic        INST_LB,
  input  logic        INST_LH,
  input  logic        INST_LW,
  input  logic        INST_LBU,
  input  logic        INST_LHU,
  input  logic        INST_SB,
  input  logic        INST_SH,
  input  logic        INST_SW,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA_IN,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic        LOAD_VALID,
  output logic [31:0] RDATA_OUT,
  kairo_lsu_if.master bus
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t      state_q, state_d;
  logic        done_q, done_d, err_q, err_d, lv_q, lv_d;
  logic [31:0] rdata_q, rdata_d, addr_q, addr_d, wd_q, wd_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  lane_q, lane_d;
  logic        we_q, we_d, isb_q, isb_d, ish_q, ish_d, sext_q, sext_d;
  logic [7:0]  inst;
  logic        byte_op, half_op, word_op, mis, expire;
  logic [31:0] bsel, ld_res;
  logic [15:0] half_v;
  assign inst    = {INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU, INST_SB, INST_SH, INST_SW};
  assign byte_op = INST_LB | INST_LBU | INST_SB;
  assign half_op = INST_LH | INST_LHU | INST_SH;
  assign word_op = INST_LW | INST_SW;
  assign mis     = (half_op & ADDR[0]) | (word_op & |ADDR[1:0]);
  assign bsel    = bus.D_RDATA >> {lane_q, 3'b000};
  assign half_v  = lane_q[1] ? bus.D_RDATA[31:16] : bus.D_RDATA[15:0];
  assign ld_res  = isb_q ? {{24{sext_q & bsel[7]}}, bsel[7:0]} :
                   ish_q ? {{16{sext_q & half_v[15]}}, half_v} : bus.D_RDATA;
`ifdef KAIRO_LSU_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  assign expire = !bus.D_ACK && ({1'b0, cnt_q} + 17'd1 >= 17'(TIMEOUT_CYCLES));
  // wait-state counter: held at zero outside ACCESS so it is clear on entry
  always_comb cnt_d = (state_q == ACCESS && !bus.D_ACK) ? cnt_q + 16'd1 : 16'd0;
  // counter register
  always_ff @(posedge CLK or posedge RST)
    if (RST) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign expire = 1'b0;
`endif
  assign BUSY        = state_q == ACCESS;
  assign DONE        = done_q;
  assign ERR         = err_q;
  assign LOAD_VALID  = lv_q;
  assign RDATA_OUT   = rdata_q;
  assign bus.D_REQ   = state_q == ACCESS;
  assign bus.D_WE    = we_q;
  assign bus.D_ADDR  = addr_q;
  assign bus.D_BE    = be_q;
  assign bus.D_WDATA = wd_q;
  // next state: accept/reject in IDLE, finish on ack or timeout in ACCESS; illegal multi-hot reports an error
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    lv_d    = 1'b0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    be_d    = be_q;
    lane_d  = lane_q;
    we_d    = we_q;
    isb_d   = isb_q;
    ish_d   = ish_q;
    sext_d  = sext_q;
    if (state_q == IDLE) begin
      if (REQ && |inst) begin
        if (!$onehot(inst) || mis) begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end else begin
          state_d = ACCESS;
          addr_d  = {ADDR[31:2], 2'b00};
          lane_d  = ADDR[1:0];
          we_d    = INST_SB | INST_SH | INST_SW;
          isb_d   = byte_op;
          ish_d   = half_op;
          sext_d  = INST_LB | INST_LH;
          be_d    = byte_op ? 4'b0001 << ADDR[1:0] : half_op ? (ADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
          wd_d    = INST_SB ? {4{WDATA_IN[7:0]}} : INST_SH ? {2{WDATA_IN[15:0]}} : INST_SW ? WDATA_IN : 32'd0;
        end
      end
    end else if (bus.D_ACK) begin
      state_d = IDLE;
      done_d  = 1'b1;
      lv_d    = !we_q;
      rdata_d = we_q ? rdata_q : ld_res;
    end else if (expire) begin
      state_d = IDLE;
      done_d  = 1'b1;
      err_d   = 1'b1;
    end
  end
  // state and registered outputs
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      lv_q    <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      be_q    <= '0;
      lane_q  <= '0;
      we_q    <= 1'b0;
      isb_q   <= 1'b0;
      ish_q   <= 1'b0;
      sext_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      lv_q    <= lv_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      be_q    <= be_d;
      lane_q  <= lane_d;
      we_q    <= we_d;
      isb_q   <= isb_d;
      ish_q   <= ish_d;
      sext_q  <= sext_d;
    end
endmodule

// File: tb/tb_kairo_lsu.sv
// tb_kairo_lsu: directed self-checking bench for kairo_lsu (honours KAIRO_LSU_TIMEOUT_EN)
module tb_kairo_lsu;
  localparam logic [7:0] OP_LB = 8'h80, OP_LH = 8'h40, OP_LW = 8'h20, OP_LBU = 8'h10;
  localparam logic [7:0] OP_LHU = 8'h08, OP_SB = 8'h04, OP_SH = 8'h02, OP_SW = 8'h01;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        REQ = 1'b0;
  logic [7:0]  inst = '0;
  logic [31:0] ADDR = '0;
  logic [31:0] WDATA_IN = '0;
  logic        BUSY, DONE, ERR, LOAD_VALID;
  logic [31:0] RDATA_OUT;
  int compared = 0;
  int mismatched = 0;
  kairo_lsu_if bus();
  kairo_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ),
    .INST_LB(inst[7]), .INST_LH(inst[6]), .INST_LW(inst[5]), .INST_LBU(inst[4]),
    .INST_LHU(inst[3]), .INST_SB(inst[2]), .INST_SH(inst[1]), .INST_SW(inst[0]),
    .ADDR(ADDR), .WDATA_IN(WDATA_IN), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .LOAD_VALID(LOAD_VALID), .RDATA_OUT(RDATA_OUT), .bus(bus)
  );
  always #5 CLK = ~CLK;
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] w);
    REQ = 1'b1; inst = op; ADDR = a; WDATA_IN = w;
    tick();
    REQ = 1'b0; inst = '0;
  endtask
  task automatic test_reset();
    bus.D_ACK = 1'b0; bus.D_RDATA = '0;
    #2 RST = 1'b1;
    tick(); tick();
    compared++; if ({BUSY, DONE, ERR, LOAD_VALID, bus.D_REQ, bus.D_WE} !== 6'b0) begin mismatched++; $display("FAIL reset_flags got %b want 000000", {BUSY, DONE, ERR, LOAD_VALID, bus.D_REQ, bus.D_WE}); end
    compared++; if (RDATA_OUT !== 32'h0) begin mismatched++; $display("FAIL reset_rdata got %h want 0", RDATA_OUT); end
    compared++; if ({bus.D_ADDR, bus.D_BE, bus.D_WDATA} !== 68'h0) begin mismatched++; $display("FAIL reset_bus got %h want 0", {bus.D_ADDR, bus.D_BE, bus.D_WDATA}); end
    RST = 1'b0;
    tick();
  endtask
  task automatic test_lw();
    issue(OP_LW, 32'h100, 32'h0);
    compared++; if ({bus.D_REQ, BUSY, bus.D_WE, DONE} !== 4'b1100) begin mismatched++; $display("FAIL lw_req got %b want 1100", {bus.D_REQ, BUSY, bus.D_WE, DONE}); end
    compared++; if (bus.D_ADDR !== 32'h100 || bus.D_BE !== 4'b1111) begin mismatched++; $display("FAIL lw_addr_be got %h/%b want 100/1111", bus.D_ADDR, bus.D_BE); end
    bus.D_ACK = 1'b1; bus.D_RDATA = 32'hDEADBEEF;
    tick();
    bus.D_ACK = 1'b0;
    compared++; if ({DONE, LOAD_VALID, ERR, bus.D_REQ, BUSY} !== 5'b11000) begin mismatched++; $display("FAIL lw_done got %b want 11000", {DONE, LOAD_VALID, ERR, bus.D_REQ, BUSY}); end
    compared++; if (RDATA_OUT !== 32'hDEADBEEF) begin mismatched++; $display("FAIL lw_rdata got %h want deadbeef", RDATA_OUT); end
    tick();
    compared++; if ({DONE, LOAD_VALID} !== 2'b00) begin mismatched++; $display("FAIL lw_pulse got %b want 00", {DONE, LOAD_VALID}); end
  endtask
  task automatic test_load_ext();
    logic [7:0]  ops [3] = '{OP_LB, OP_LBU, OP_LHU};
    logic [31:0] adr [3] = '{32'h103, 32'h103, 32'h102};
    logic [3:0]  bes [3] = '{4'b1000, 4'b1000, 4'b1100};
    logic [31:0] exp [3] = '{32'hFFFFFF80, 32'h00000080, 32'h00008012};
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], adr[i], 32'h0);
      compared++; if (bus.D_BE !== bes[i] || bus.D_ADDR !== 32'h100) begin mismatched++; $display("FAIL ext%0d_be got %b/%h want %b/100", i, bus.D_BE, bus.D_ADDR, bes[i]); end
      bus.D_ACK = 1'b1; bus.D_RDATA = 32'h80123456;
      tick();
      bus.D_ACK = 1'b0;
      compared++; if (RDATA_OUT !== exp[i] || LOAD_VALID !== 1'b1) begin mismatched++; $display("FAIL ext%0d_rdata got %h lv=%b want %h lv=1", i, RDATA_OUT, LOAD_VALID, exp[i]); end
      tick();
    end
  endtask
  task automatic test_store_wait();
    issue(OP_SH, 32'h202, 32'h1234ABCD);
    for (int i = 0; i < 4; i++) begin
      compared++; if ({bus.D_REQ, bus.D_WE, bus.D_BE} !== 6'b111100 || bus.D_WDATA !== 32'hABCDABCD || DONE !== 1'b0) begin mismatched++; $display("FAIL sh_hold%0d got req/we/be=%b wd=%h done=%b want 111100 abcdabcd 0", i, {bus.D_REQ, bus.D_WE, bus.D_BE}, bus.D_WDATA, DONE); end
      bus.D_ACK = (i == 3);
      tick();
    end
    bus.D_ACK = 1'b0;
    compared++; if ({DONE, LOAD_VALID, ERR, bus.D_REQ} !== 4'b1000) begin mismatched++; $display("FAIL sh_done got %b want 1000", {DONE, LOAD_VALID, ERR, bus.D_REQ}); end
    compared++; if (RDATA_OUT !== 32'h00008012) begin mismatched++; $display("FAIL sh_rdata got %h want 00008012", RDATA_OUT); end
    tick();
  endtask
  task automatic test_back_to_back();
    REQ = 1'b1; inst = OP_LW; ADDR = 32'h101;
    tick();
    compared++; if ({DONE, ERR, bus.D_REQ, BUSY, LOAD_VALID} !== 5'b11000) begin mismatched++; $display("FAIL mis_err got %b want 11000", {DONE, ERR, bus.D_REQ, BUSY, LOAD_VALID}); end
    ADDR = 32'h104;
    tick();
    REQ = 1'b0; inst = '0;
    compared++; if ({bus.D_REQ, DONE, ERR} !== 3'b100 || bus.D_ADDR !== 32'h104) begin mismatched++; $display("FAIL b2b_req got %b/%h want 100/104", {bus.D_REQ, DONE, ERR}, bus.D_ADDR); end
    bus.D_ACK = 1'b1; bus.D_RDATA = 32'h11223344;
    tick();
    bus.D_ACK = 1'b0;
    compared++; if ({DONE, ERR, LOAD_VALID} !== 3'b101 || RDATA_OUT !== 32'h11223344) begin mismatched++; $display("FAIL b2b_done got %b/%h want 101/11223344", {DONE, ERR, LOAD_VALID}, RDATA_OUT); end
    tick();
  endtask
  task automatic test_timeout();
    int n = 0;
    logic seen = 1'b0;
    logic e = 1'b0;
    issue(OP_SW, 32'h300, 32'hCAFEF00D);
    compared++; if (bus.D_WDATA !== 32'hCAFEF00D || bus.D_BE !== 4'b1111) begin mismatched++; $display("FAIL sw_data got %h/%b want cafef00d/1111", bus.D_WDATA, bus.D_BE); end
`ifdef KAIRO_LSU_TIMEOUT_EN
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.D_REQ) n++;
      if (DONE) begin seen = 1'b1; e = ERR; end
      else tick();
    end
    compared++; if (n !== 4 || !seen || e !== 1'b1) begin mismatched++; $display("FAIL timeout got req_cycles=%0d done=%b err=%b want 4 1 1", n, seen, e); end
    compared++; if (RDATA_OUT !== 32'h11223344 || LOAD_VALID !== 1'b0) begin mismatched++; $display("FAIL timeout_rdata got %h lv=%b want 11223344 0", RDATA_OUT, LOAD_VALID); end
    tick();
`else
    for (int i = 0; i < 12; i++) begin
      if (bus.D_REQ && !DONE) n++;
      tick();
    end
    compared++; if (n !== 12) begin mismatched++; $display("FAIL no_timeout got req_cycles=%0d want 12", n); end
    bus.D_ACK = 1'b1;
    tick();
    bus.D_ACK = 1'b0;
    compared++; if ({DONE, ERR, LOAD_VALID} !== 3'b100 || RDATA_OUT !== 32'h11223344) begin mismatched++; $display("FAIL late_ack got %b/%h want 100/11223344", {DONE, ERR, LOAD_VALID}, RDATA_OUT); end
    tick();
`endif
  endtask
  task automatic test_reset_mid();
    int d = 0;
    issue(OP_LW, 32'h400, 32'h0);
    tick();
    RST = 1'b1;
    #1;
    compared++; if ({bus.D_REQ, BUSY, DONE, ERR, LOAD_VALID} !== 5'b0 || RDATA_OUT !== 32'h0) begin mismatched++; $display("FAIL mid_reset got %b/%h want 00000/0", {bus.D_REQ, BUSY, DONE, ERR, LOAD_VALID}, RDATA_OUT); end
    tick();
    RST = 1'b0;
    bus.D_ACK = 1'b1; bus.D_RDATA = 32'h55AA55AA;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (DONE || bus.D_REQ) d++;
    end
    bus.D_ACK = 1'b0;
    compared++; if (d !== 0) begin mismatched++; $display("FAIL abandoned got done_or_req_cycles=%0d want 0", d); end
  endtask
  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store_wait();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/kairo_lsu.md
# kairo_lsu

Load/store unit sitting directly downstream of the integer ALU. It takes the ALU's effective address (`RSLT_A`) together with the decoded load/store strobe and `RS2`, and runs one data-bus transaction through a req/ack handshake. It handles byte-lane steering for stores, and alignment plus sign/zero extension for loads. Completion or error is reported to the writeback/control logic with a one-cycle pulse.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 255: ACCESS cycles without `D_ACK` before abort. Legal range 1..65535. Used only when the timeout feature is compiled in.

Ports:
- `CLK`  in  1  sole clock, rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `REQ`  in  1  start strobe. Sampled only in IDLE.
- `INST_LB`, `INST_LH`, `INST_LW`, `INST_LBU`, `INST_LHU`, `INST_SB`, `INST_SH`, `INST_SW`  in  1 each  operation select, one-hot, valid with `REQ`.
- `ADDR`  in  32  effective address (ALU `RSLT_A`), valid with `REQ`.
- `WDATA_IN`  in  32  store data (`RS2`), valid with `REQ`.
- `BUSY`  out  1  high while in ACCESS.
- `DONE`  out  1  one-cycle completion pulse.
- `ERR`  out  1  qualifies `DONE`: misaligned access or timeout.
- `LOAD_VALID`  out  1  pulses with `DONE` for an error-free load.
- `RDATA_OUT`  out  32  extended load result. Holds until the next successful load.
- `D_REQ`  out  1  bus request. Held until ack or abort.
- `D_WE`  out  1  1 = store.
- `D_ADDR`  out  32  word address, `{ADDR[31:2],2'b00}`.
- `D_BE`  out  4  byte enables.
- `D_WDATA`  out  32  lane-replicated store data.
- `D_ACK`  in  1  bus acknowledge. For loads, `D_RDATA` is valid in the same cycle.
- `D_RDATA`  in  32  bus read data.

## Operation

- States: IDLE, ACCESS. All outputs are registered. On reset, all outputs are 0, `RDATA_OUT` = 0, state = IDLE, timeout counter = 0.
- IDLE:
  - `REQ` with exactly one INST_* high captures the operation, address, data and byte lane.
  - `REQ` with no INST_* high is ignored.
  - Multi-hot INST_* is illegal and produces undefined data, but the FSM must still return to IDLE.
- Misalignment:
  - Misaligned cases: LH/LHU/SH with `ADDR[0]`=1; LW/SW with `ADDR[1:0]`≠0.
  - Result: no bus cycle. `DONE`=`ERR`=1 next cycle. State stays IDLE.
- Aligned access:
  - Transition to ACCESS. `D_REQ`=1, and `D_WE`, `D_ADDR`, `D_BE`, `D_WDATA` are driven and held stable until exit.
- Byte enables:
  - Byte ops: `1<<ADDR[1:0]`.
  - Half ops: `0011` for `ADDR[1]`=0, `1100` for `ADDR[1]`=1.
  - Word ops: `1111`.
- Store data:
  - SB: `{4{WDATA_IN[7:0]}}`.
  - SH: `{2{WDATA_IN[15:0]}}`.
  - SW: `WDATA_IN`.
  - Loads drive `D_WDATA`=0.
- ACCESS with `D_ACK`=1:
  - Return to IDLE and pulse `DONE` next cycle.
  - For loads, select the lane from `D_RDATA` by the captured `ADDR[1:0]`. LB/LH sign-extend; LBU/LHU zero-extend. Register into `RDATA_OUT` and pulse `LOAD_VALID`.
- Stores never modify `RDATA_OUT`.
- `D_ACK` in IDLE is ignored.
- `REQ` in ACCESS is ignored; upstream must stall on `BUSY`.

## Timing

- `REQ` accepted at edge ending cycle T → `D_REQ`/`BUSY` high in T+1.
- `D_ACK` high in T+1 → `D_REQ`/`BUSY` low, `DONE` high in T+2; `RDATA_OUT` valid in T+2.
- A new `REQ` may be presented in the `DONE` cycle. Peak throughput is one access per 2 cycles.
- Each wait-state cycle (`D_ACK` low) adds one cycle.
- Misaligned: `REQ` at T → `DONE`/`ERR` in T+1, with `D_REQ` never asserted.
- `DONE`, `ERR` and `LOAD_VALID` are single-cycle pulses.
- Reset asserted mid-ACCESS: `D_REQ` drops asynchronously, the transaction is abandoned, and no `DONE` is produced. The bus slave must tolerate an abandoned request.

## Configuration

- `KAIRO_LSU_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle with `D_ACK`=0.
  - When it reaches `TIMEOUT_CYCLES`, `D_REQ` drops and `DONE`=`ERR`=1 next cycle; a load then does not update `RDATA_OUT`.
  - If `D_ACK` and expiry coincide, the ack wins and completion is normal.
- Macro undefined: no counter. ACCESS waits indefinitely for `D_ACK`, and `ERR` is raised only for misalignment.

## Test plan

- LW, `ADDR`=0x100; slave acks in T+1 with 0xDEADBEEF → `D_ADDR`=0x100, `D_BE`=1111, `D_WE`=0; `DONE`+`LOAD_VALID` in T+2; `RDATA_OUT`=0xDEADBEEF.
- LB, `ADDR`=0x103, `D_RDATA`=0x80123456 → `D_BE`=1000, `RDATA_OUT`=0xFFFFFF80. Repeat as LBU → 0x00000080. Repeat as LHU, `ADDR`=0x102 → 0x00008012.
- SH, `ADDR`=0x202, `WDATA_IN`=0x1234ABCD, ack after 3 wait cycles → `D_WE`=1, `D_BE`=1100, `D_WDATA`=0xABCDABCD held 4 cycles; `DONE` with `LOAD_VALID`=0; `RDATA_OUT` unchanged.
- LW, `ADDR`=0x101 → `D_REQ` never asserted; `DONE`=`ERR`=1 in T+1; back-to-back `REQ` in T+1 is accepted.
- `TIMEOUT_CYCLES`=4, SW never acked → with macro: `D_REQ` high exactly 4 cycles, then `DONE`=`ERR`=1. Without macro: `D_REQ` stays high indefinitely.
- `RST` pulsed in 2nd ACCESS cycle → `D_REQ`/`BUSY` low immediately, all outputs 0; a later `D_ACK` produces no `DONE`.
